// File: rtl/mem_stage_pkg.sv
// Shared encodings for the wait-state MEM stage: FSM state values and byte-to-word shift.
package mem_stage_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_BUSY = S_BUSY,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/mem_ws_ram.sv
// Word-addressed storage array: synchronous write, registered read, no reset on contents.
module mem_ws_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_stage_ws.sv
// MEM pipeline stage with a configurable-latency data memory; ready=0 freezes the earlier stages.
//  state | meaning
//  IDLE  | no access in flight; a request starts the wait sequence
//  BUSY  | counting down wait states; the access happens on the edge where cnt hits 0
//  DONE  | access complete, results presented, ready=1 for this one cycle
module mem_stage_ws
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 2048,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic              WB_EN,
    input  logic [DATA_W-1:0] ALU_Res,
    input  logic [DATA_W-1:0] Val_Rm,
    input  logic [3:0]        Dest,
    output logic [DATA_W-1:0] MEM_Result,
    output logic [DATA_W-1:0] ALU_Res_out,
    output logic [3:0]        Dest_out,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic              ready,
    output logic              addr_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [DATA_W-1:0] BASE_W   = DATA_W'(BASE_ADDR);
    localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               rdata_ok_q;
    logic               err_q;

    logic               req;
    logic               is_store;
    logic               is_load;
    logic               in_range;
    logic               access;
    logic [DATA_W-1:0]  offset;
    logic [ADDR_W-1:0]  idx;
    logic [DATA_W-1:0]  ram_rdata;

    assign req      = MEM_R_EN | MEM_W_EN;
    assign is_store = MEM_W_EN;
    assign is_load  = MEM_R_EN & ~MEM_W_EN;

    // Byte offset from the window base; the low two bits are dropped by the shift.
    assign offset   = ALU_Res - BASE_W;
    assign idx      = offset[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
    assign in_range = (ALU_Res >= BASE_W) && ((offset >> WORD_SHIFT) < DEPTH_W);

    assign access   = (state == ST_BUSY) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rdata_ok_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_DONE;
                        err_q <= ~in_range;
                        if (is_load) begin
                            rdata_ok_q <= in_range;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_ws_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (access & is_store & in_range),
        .re    (access & is_load & in_range),
        .addr  (idx),
        .wdata (Val_Rm),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset, so a reset or out-of-range load forces the result to zero here.
    assign MEM_Result   = rdata_ok_q ? ram_rdata : '0;

    assign ready        = ((state == ST_IDLE) && !req) || (state == ST_DONE);
    assign addr_err     = err_q && (state == ST_DONE);

    assign ALU_Res_out  = ALU_Res;
    assign Dest_out     = Dest;
    assign WB_EN_out    = WB_EN;
    assign MEM_R_EN_out = MEM_R_EN;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Scoreboard bench for mem_stage_ws: driver queues expected completions, monitor checks on ready.
module tb_mem_stage_ws;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r_en, w_en, wb_en, sel1;
    logic [31:0] alu, val;
    logic [3:0]  dest;

    logic        r0, w0, r1, w1;
    logic [31:0] res0, alu0, res1, alu1;
    logic [3:0]  dest0, dest1;
    logic        wb0, ren0, ready0, err0, wb1, ren1, ready1, err1;

    assign r0 = r_en & ~sel1;
    assign w0 = w_en & ~sel1;
    assign r1 = r_en & sel1;
    assign w1 = w_en & sel1;

    mem_stage_ws #(.WAIT_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r0), .MEM_W_EN(w0), .WB_EN(wb_en),
        .ALU_Res(alu), .Val_Rm(val), .Dest(dest),
        .MEM_Result(res0), .ALU_Res_out(alu0), .Dest_out(dest0), .WB_EN_out(wb0),
        .MEM_R_EN_out(ren0), .ready(ready0), .addr_err(err0)
    );

    mem_stage_ws #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(w1), .WB_EN(wb_en),
        .ALU_Res(alu), .Val_Rm(val), .Dest(dest),
        .MEM_Result(res1), .ALU_Res_out(alu1), .Dest_out(dest1), .WB_EN_out(wb1),
        .MEM_R_EN_out(ren1), .ready(ready1), .addr_err(err1)
    );

    logic [31:0] m_res, m_alu;
    logic [3:0]  m_dest;
    logic        m_wb, m_ren, m_ready, m_err;
    assign m_res   = sel1 ? res1   : res0;
    assign m_alu   = sel1 ? alu1   : alu0;
    assign m_dest  = sel1 ? dest1  : dest0;
    assign m_wb    = sel1 ? wb1    : wb0;
    assign m_ren   = sel1 ? ren1   : ren0;
    assign m_ready = sel1 ? ready1 : ready0;
    assign m_err   = sel1 ? err1   : err0;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        err;
        int          stall;
        logic [31:0] alu;
        logic [3:0]  dest;
        logic        wb;
        logic        ren;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   passed = 0;
    int   total = 0;
    int   issue_cnt = 0;
    int   done_cnt = 0;
    int   stall_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (issue_cnt != done_cnt) begin
            if (!m_ready) begin
                stall_cnt++;
            end else begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL scoreboard: completion seen with empty queue");
                end else begin
                    e_mon = sb.pop_front();
                    chk({e_mon.name, ".result"}, m_res, e_mon.result);
                    chk({e_mon.name, ".addr_err"}, 32'(m_err), 32'(e_mon.err));
                    chk({e_mon.name, ".stall"}, stall_cnt, e_mon.stall);
                    chk({e_mon.name, ".alu_out"}, m_alu, e_mon.alu);
                    chk({e_mon.name, ".dest_out"}, 32'(m_dest), 32'(e_mon.dest));
                    chk({e_mon.name, ".wb_out"}, 32'(m_wb), 32'(e_mon.wb));
                    chk({e_mon.name, ".ren_out"}, 32'(m_ren), 32'(e_mon.ren));
                end
                stall_cnt = 0;
                done_cnt++;
            end
        end
    end

    task automatic do_op(string nm, logic r, logic w, logic wb, logic [31:0] a, logic [31:0] d,
                         logic [3:0] ds, logic [31:0] er, logic ee, int es);
        exp_t e;
        int   k;
        e.name = nm; e.result = er; e.err = ee; e.stall = es;
        e.alu = a; e.dest = ds; e.wb = wb; e.ren = r;
        @(posedge clk); #1;
        r_en = r; w_en = w; wb_en = wb; alu = a; val = d; dest = ds;
        sb.push_back(e);
        issue_cnt++;
        k = 0;
        while (done_cnt != issue_cnt && k < 40) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt != issue_cnt) begin
            total++;
            $display("FAIL %s.timeout: no ready after %0d cycles, expected stall %0d", nm, k, es);
            $display("%0d/%0d checks passed", passed, total);
            $finish;
        end
        #1;
        r_en = 1'b0; w_en = 1'b0; wb_en = 1'b0;
    endtask

    initial begin
        sel1 = 1'b0;
        rst = 1'b0;
        r_en = 1'b1; w_en = 1'b0; wb_en = 1'b1;
        alu = 32'h0000_0400; val = 32'h0; dest = 4'h2;
        #2;
        chk("reset.result", res0, 32'h0);
        chk("reset.addr_err", 32'(err0), 32'h0);
        chk("reset.ready_req", 32'(ready0), 32'h0);
        chk("reset.alu_out", alu0, 32'h0000_0400);
        r_en = 1'b0; wb_en = 1'b0;
        #1;
        chk("reset.ready_idle", 32'(ready0), 32'h1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        do_op("st_400",   0, 1, 0, 32'h400,  32'hDEADBEEF, 4'h1, 32'h0, 0, 5);
        do_op("st_408",   0, 1, 0, 32'h408,  32'h0,        4'h1, 32'h0, 0, 5);
        do_op("st_23fc",  0, 1, 0, 32'h23FC, 32'h0,        4'h1, 32'h0, 0, 5);
        do_op("ld_400",   1, 0, 1, 32'h400,  32'h0,        4'h5, 32'hDEADBEEF, 0, 5);
        do_op("st_404",   0, 1, 0, 32'h404,  32'h12345678, 4'h1, 32'hDEADBEEF, 0, 5);
        do_op("ld_404",   1, 0, 1, 32'h404,  32'h0,        4'h6, 32'h12345678, 0, 5);
        do_op("ld_3fc",   1, 0, 1, 32'h3FC,  32'h0,        4'h7, 32'h0, 1, 5);
        do_op("ld_2400",  1, 0, 1, 32'h2400, 32'h0,        4'h7, 32'h0, 1, 5);
        do_op("st_3fc",   0, 1, 0, 32'h3FC,  32'h11111111, 4'h1, 32'h0, 1, 5);
        do_op("st_2400",  0, 1, 0, 32'h2400, 32'h22222222, 4'h1, 32'h0, 1, 5);
        do_op("ld_23fc",  1, 0, 1, 32'h23FC, 32'h0,        4'h8, 32'h0, 0, 5);
        do_op("ld_400b",  1, 0, 1, 32'h400,  32'h0,        4'h9, 32'hDEADBEEF, 0, 5);
        do_op("nonmem",   0, 0, 1, 32'h55,   32'h0,        4'h3, 32'hDEADBEEF, 0, 0);
        do_op("ld_404b",  1, 0, 1, 32'h404,  32'h0,        4'h6, 32'h12345678, 0, 5);

        // Store interrupted by reset two cycles into BUSY.
        @(posedge clk); #1;
        w_en = 1'b1; alu = 32'h408; val = 32'hAAAA5555;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid.result", res0, 32'h0);
        chk("rst_mid.ready_req", 32'(ready0), 32'h0);
        w_en = 1'b0;
        #1;
        chk("rst_mid.ready_idle", 32'(ready0), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid.idle_after", 32'(ready0), 32'h1);

        do_op("ld_408",   1, 0, 1, 32'h408,  32'h0,        4'hA, 32'h0, 0, 5);
        do_op("ld_404c",  1, 0, 1, 32'h404,  32'h0,        4'h6, 32'h12345678, 0, 5);
        do_op("both_40c", 1, 1, 1, 32'h40C,  32'h7,        4'hB, 32'h12345678, 0, 5);
        do_op("ld_40c",   1, 0, 1, 32'h40C,  32'h0,        4'hC, 32'h7, 0, 5);

        @(posedge clk); #1 sel1 = 1'b1;
        do_op("w1_both",  1, 1, 1, 32'h40C,  32'h7,        4'hB, 32'h0, 0, 2);
        do_op("w1_ld",    1, 0, 1, 32'h40C,  32'h0,        4'hC, 32'h7, 0, 2);
        do_op("w1_oor",   1, 0, 0, 32'h2400, 32'h0,        4'hD, 32'h0, 1, 2);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard.leftover: %0d entries remain, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
